// File: rtl/comparador_pkg.sv
// Shared types for the MSB-first serial comparator.
// Optional macro CMP_SIGNED_EN selects two's complement words.
package comparador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EQ   = 2'd1,
    ST_GT   = 2'd2,
    ST_LT   = 2'd3
  } state_t;

  localparam int RES_GT = 2;
  localparam int RES_EQ = 1;
  localparam int RES_LT = 0;

`ifdef CMP_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  function automatic logic [2:0] res_of(input state_t s);
    logic [2:0] r;
    r = '0;
    case (s)
      ST_GT:   r[RES_GT] = 1'b1;
      ST_LT:   r[RES_LT] = 1'b1;
      default: r[RES_EQ] = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparador_serie_i_d_celda.sv
// Next-state cell for the MSB-first comparator.
// With CMP_SIGNED_EN the sign beat inverts the decision.
module celda_inicial_i_d
  import comparador_pkg::*;
(
  input  state_t state,
  input  logic   a_bit,
  input  logic   b_bit,
  input  logic   first,
  output state_t next
);

  logic inv;

  // A sign bit set means the smaller value in two's complement.
  assign inv = first & SIGNED_EN;

  // Only an undecided word can move; GT/LT are final.
  always_comb begin
    next = state;
    if (state == ST_EQ) begin
      unique case (1'b1)
        a_bit & ~b_bit: next = inv ? ST_LT : ST_GT;
        ~a_bit & b_bit: next = inv ? ST_GT : ST_LT;
        default:        next = ST_EQ;
      endcase
    end
  end

endmodule

// File: rtl/comparador_serie_i_d.sv
// Bit-serial MSB-first magnitude comparator, 3-way result.
// Optional macro CMP_SIGNED_EN: two's complement words.
module comparador_serie_i_d
  import comparador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [2:0]      res;

  assign last = (cnt == CW'(WIDTH - 1));

  celda_inicial_i_d u_celda (
    .state (state),
    .a_bit (a_bit),
    .b_bit (b_bit),
    .first (cnt == '0),
    .next  (nxt)
  );

  // FSM, bit counter and result registers; start overrides a final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else if (start) begin
      state <= ST_EQ;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      res   <= '0;
    end else if (busy && bit_valid) begin
      cnt <= cnt + CW'(1);
      if (last) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
        res   <= res_of(nxt);
      end else begin
        state <= nxt;
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign a_gt_b = res[RES_GT];
  assign a_eq_b = res[RES_EQ];
  assign a_lt_b = res[RES_LT];

endmodule

// File: tb/tb_comparador_serie_i_d.sv
// Self-checking bench for comparador_serie_i_d (WIDTH=8).
// Scoreboard of expected results popped on each done pulse.
module tb_comparador_serie_i_d;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic busy, done, a_gt_b, a_eq_b, a_lt_b;

  comparador_serie_i_d #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b),
    .a_lt_b    (a_lt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   u;
    logic [2:0]   s;
    bit           gap;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] pick(input vec_t v);
`ifdef CMP_SIGNED_EN
    return v.s;
`else
    return v.u;
`endif
  endfunction

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, e.res});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start with bit_valid high (ignored), then shift W bit pairs.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit gap, input logic [2:0] res);
    exp_t e;
    e.res = res;
    e.cyc = cyc + W + 1 + (gap ? W - 1 : 0);
    q.push_back(e);
    start = 1'b1;
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b0;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("res_cleared", {29'd0, a_gt_b, a_eq_b, a_lt_b}, 32'd0);
    for (int i = 0; i < W; i++) begin
      bit_valid = 1'b1;
      a_bit = a[W-1-i];
      b_bit = b[W-1-i];
      tick();
      if (gap && i < W - 1) begin
        bit_valid = 1'b0;
        a_bit = ~a_bit;
        b_bit = $urandom_range(0, 1);
        tick();
      end
    end
    bit_valid = 1'b0;
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic partial(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int n);
    start = 1'b1;
    bit_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      a_bit = a[W-1-i];
      b_bit = b[W-1-i];
      tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      check("timeout_done", 32'd1, 32'd0);
      q.delete();
    end
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    logic [2:0] held;
    vecs[0] = '{8'hA5, 8'hA5, EQ, EQ, 1'b0};
    vecs[1] = '{8'h80, 8'h7F, GT, LT, 1'b0};
    vecs[2] = '{8'h12, 8'h13, LT, LT, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, LT, GT, 1'b0};
    vecs[4] = '{8'hFF, 8'hFE, GT, GT, 1'b0};
    vecs[5] = '{8'h01, 8'h00, GT, GT, 1'b1};
    vecs[6] = '{8'h7F, 8'h80, LT, GT, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, EQ, EQ, 1'b0};

    #12;
    check("reset_outs", {27'd0, busy, done, a_gt_b, a_eq_b, a_lt_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_outs", {27'd0, busy, done, a_gt_b, a_eq_b, a_lt_b}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i].a, vecs[i].b, vecs[i].gap, pick(vecs[i]));
      drain();
    end

    // Abort after 4 beats, then a clean zero compare.
    partial(8'hFF, 8'h00, 4);
    send_word(8'h00, 8'h00, 1'b0, EQ);
    drain();

    // Start on the final beat of a word: old word yields no done.
    partial(8'h00, 8'hFF, W - 1);
    send_word(8'h3C, 8'h3C, 1'b0, EQ);
    drain();

    // Reset at beat 5 of FF vs 00.
    partial(8'hFF, 8'h00, 4);
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {27'd0, busy, done, a_gt_b, a_eq_b, a_lt_b}, 32'd0);
    bit_valid = 1'b0;
    tick();
    tick();
    check("reset_hold", {27'd0, busy, done, a_gt_b, a_eq_b, a_lt_b}, 32'd0);
    rst_n = 1'b1;
    tick();
    send_word(8'hFF, 8'h00, 1'b0, GT);
    drain();

    // bit_valid toggling while idle leaves the result alone.
    send_word(8'h12, 8'h13, 1'b0, LT);
    drain();
    held = LT;
    for (int i = 0; i < 6; i++) begin
      bit_valid = i[0];
      a_bit = $urandom_range(0, 1);
      b_bit = $urandom_range(0, 1);
      tick();
      check("idle_hold", {28'd0, done, a_gt_b, a_eq_b, a_lt_b},
            {28'd0, 1'b0, held});
    end
    bit_valid = 1'b0;
    tick();
    check("queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
